ysyx_25020047_lsu: RTL and testbench

//  Load/store stage between EXU and WBU. Accepts one instruction at a time (inst_type, result, sdata, snpc).

---
 rtl/ysyx_25020047_lsu.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_25020047_lsu.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_lsu.sv
// Load/store stage between EXU and WBU: one instruction in flight, a word-wide
// memory request/response handshake, and a single registered result slot toward WBU.
module ysyx_25020047_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [8:0]  in_type,
   input  logic [31:0] in_result,
   input  logic [31:0] in_sdata,
   input  logic [31:0] in_snpc,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [8:0]  out_type,
   output logic [31:0] out_result,
   output logic [31:0] out_memdata,
   output logic [31:0] out_snpc,
   output logic        err
);
   localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

   state_t      state_r, state_s;
   logic [8:0]  type_r;
   logic [31:0] result_r, snpc_r;
   logic [7:0]  cnt_r, cnt_inc_s;
   logic        accept_s, is_mem_s, misalign_s, tmo_s;
   logic        out_load_s, err_s;
   logic [8:0]  load_type_s;
   logic [31:0] load_result_s, load_memdata_s, load_snpc_s, rd_data_s;

   function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] sel);
      case (sel)
         2'd0:    byte_lane = word[7:0];
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         default: byte_lane = word[31:24];
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [8:0] t, input logic [1:0] off);
      if (t[7])      store_mask = 4'b1111;
      else if (t[8]) store_mask = 4'b0001 << off;
      else           store_mask = 4'b0000;
   endfunction

   function automatic logic [31:0] store_data(input logic [8:0] t, input logic [31:0] sd);
      if (t[7])      store_data = sd;
      else if (t[8]) store_data = {4{sd[7:0]}};
      else           store_data = 32'd0;
   endfunction

   assign in_ready   = (state_r == S_IDLE) & (~out_valid | out_ready);
   assign accept_s   = in_valid & in_ready;
   assign is_mem_s   = |in_type[8:5];
   assign misalign_s = (in_type[5] | in_type[7]) & (in_result[1:0] != 2'b00);
   assign cnt_inc_s  = cnt_r + 8'd1;
   assign tmo_s      = (cnt_inc_s == TIMEOUT_C);

   // Load data extraction from the returned word
   always_comb begin
      if (type_r[5])      rd_data_s = mem_rdata;
      else if (type_r[6]) rd_data_s = {24'd0, byte_lane(mem_rdata, result_r[1:0])};
      else                rd_data_s = 32'd0;
   end

   // Next state and output-register load decision
   always_comb begin
      state_s        = state_r;
      out_load_s     = 1'b0;
      err_s          = 1'b0;
      load_type_s    = type_r;
      load_result_s  = result_r;
      load_memdata_s = 32'd0;
      load_snpc_s    = snpc_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               if (!is_mem_s || misalign_s) begin
                  out_load_s    = 1'b1;
                  err_s         = misalign_s;
                  load_type_s   = in_type;
                  load_result_s = in_result;
                  load_snpc_s   = in_snpc;
               end else begin
                  state_s = S_REQ;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_REQ: begin
            if (tmo_s) begin
               state_s    = S_IDLE;
               out_load_s = 1'b1;
               err_s      = 1'b1;
            end else if (mem_gnt) begin
               state_s = S_WAIT;
            end else begin
               state_s = S_REQ;
            end
         end
         S_WAIT: begin
            // a response arriving on the last allowed cycle still completes normally
            if (mem_rvalid) begin
               state_s        = S_IDLE;
               out_load_s     = 1'b1;
               load_memdata_s = rd_data_s;
            end else if (tmo_s) begin
               state_s    = S_IDLE;
               out_load_s = 1'b1;
               err_s      = 1'b1;
            end else begin
               state_s = S_WAIT;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State register and timeout counter (cleared whenever idle)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         cnt_r   <= 8'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= (state_r == S_IDLE) ? 8'd0 : cnt_inc_s;
      end
   end

   // Latched copy of the accepted instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_r   <= 9'd0;
         result_r <= 32'd0;
         snpc_r   <= 32'd0;
      end else if (accept_s) begin
         type_r   <= in_type;
         result_r <= in_result;
         snpc_r   <= in_snpc;
      end
   end

   // Memory request registers, held stable for the whole request phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wen   <= 1'b0;
         mem_wdata <= 32'd0;
         mem_wmask <= 4'd0;
      end else begin
         mem_req <= (state_s == S_REQ);
         if (accept_s && (state_s == S_REQ)) begin
            mem_addr  <= {in_result[31:2], 2'b00};
            mem_wen   <= in_type[7] | in_type[8];
            mem_wdata <= store_data(in_type, in_sdata);
            mem_wmask <= store_mask(in_type, in_result[1:0]);
         end
      end
   end

   // Result register toward WBU plus the error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_type    <= 9'd0;
         out_result  <= 32'd0;
         out_memdata <= 32'd0;
         out_snpc    <= 32'd0;
         err         <= 1'b0;
      end else begin
         err <= err_s;
         if (out_load_s) begin
            out_valid   <= 1'b1;
            out_type    <= load_type_s;
            out_result  <= load_result_s;
            out_memdata <= load_memdata_s;
            out_snpc    <= load_snpc_s;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Self-checking bench for ysyx_25020047_lsu: directed vector table, hand-written
// corner sequences, and a randomized stream checked against a behavioural model.
module tb_ysyx_25020047_lsu;
   localparam int unsigned TB_TIMEOUT = 6;
   localparam logic [8:0] T_ADDI = 9'h001, T_JALR = 9'h002, T_OTH2 = 9'h004, T_OTH3 = 9'h008,
                          T_LUI = 9'h010, T_LW = 9'h020, T_LBU = 9'h040, T_SW = 9'h080, T_SB = 9'h100;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready, err;
   logic [8:0]  in_type, out_type;
   logic [31:0] in_result, in_sdata, in_snpc, out_result, out_memdata, out_snpc;
   logic        mem_req, mem_wen;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        mem_gnt, mem_rvalid;
   logic        auto_mem, rsp_gnt, rsp_rvalid, man_gnt, man_rvalid;
   logic [31:0] rsp_rdata, man_rdata;
   int          tests = 0, fails = 0;

   assign mem_gnt    = auto_mem ? rsp_gnt    : man_gnt;
   assign mem_rvalid = auto_mem ? rsp_rvalid : man_rvalid;
   assign mem_rdata  = auto_mem ? rsp_rdata  : man_rdata;

   always #5 clk = ~clk;

   ysyx_25020047_lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
      .in_result(in_result), .in_sdata(in_sdata), .in_snpc(in_snpc), .mem_req(mem_req),
      .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type), .out_result(out_result),
      .out_memdata(out_memdata), .out_snpc(out_snpc), .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- behavioural memory and reference model ----------------
   typedef struct packed {
      logic [8:0]  typ;
      logic [31:0] result, memdata, snpc;
      logic        err;
   } beat_t;

   logic [31:0] dut_mem [int];
   logic [31:0] ref_mem [int];
   beat_t       exp_q [$];
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wmask;
   logic        exp_wen;

   function automatic logic [31:0] seed_word(input int idx);
      return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // Reference semantics of one accepted instruction; also predicts the memory request.
   task automatic model_accept(input logic [8:0] typ, input logic [31:0] res, input logic [31:0] sd,
                               input logic [31:0] snpc, output beat_t e, output bit mem_op);
      int          off, idx;
      logic [31:0] word;
      off  = int'(res % 32'd4);
      idx  = int'(res >> 2);
      word = ref_mem.exists(idx) ? ref_mem[idx] : seed_word(idx);
      e.typ = typ; e.result = res; e.snpc = snpc; e.memdata = 32'd0; e.err = 1'b0;
      mem_op = 1'b0;
      if ((typ == T_LW || typ == T_SW) && off != 0) e.err = 1'b1;
      else if (typ == T_LW)  begin mem_op = 1'b1; e.memdata = word; end
      else if (typ == T_LBU) begin mem_op = 1'b1; e.memdata = (word >> (8 * off)) & 32'hFF; end
      else if (typ == T_SW)  begin mem_op = 1'b1; ref_mem[idx] = sd; end
      else if (typ == T_SB)  begin
         mem_op = 1'b1;
         ref_mem[idx] = (word & ~(32'hFF << (8 * off))) | ((sd & 32'hFF) << (8 * off));
      end
      exp_addr  = res & ~32'h3;
      exp_wen   = (typ == T_SW) || (typ == T_SB);
      exp_wdata = (typ == T_SW) ? sd : (typ == T_SB) ? (sd & 32'hFF) * 32'h01010101 : 32'd0;
      exp_wmask = (typ == T_SW) ? 4'hF : (typ == T_SB) ? (4'h1 << off) : 4'h0;
   endtask

   // Randomly stalling memory: random grant delay, random response delay, byte-masked writes.
   initial begin : responder
      int          phase, cnt, idx;
      logic [31:0] first_addr, word, pend;
      rsp_gnt = 1'b0; rsp_rvalid = 1'b0; rsp_rdata = 32'd0; phase = 0; cnt = 0; pend = 32'd0;
      first_addr = 32'd0;
      forever begin
         @(negedge clk);
         rsp_gnt = 1'b0; rsp_rvalid = 1'b0;
         if (!auto_mem || !rst_n) begin
            phase = 0;
         end else begin
            if (phase == 1) begin
               check("rnd_req_held", {31'd0, mem_req}, 32'd1);
               check("rnd_addr_stable", mem_addr, first_addr);
               cnt--;
            end else if (phase == 2) begin
               cnt--;
               if (cnt == 0) begin rsp_rvalid = 1'b1; rsp_rdata = pend; phase = 0; end
            end else if (mem_req) begin
               check("rnd_req_addr", mem_addr, exp_addr);
               check("rnd_req_wen", {31'd0, mem_wen}, {31'd0, exp_wen});
               check("rnd_req_wdata", mem_wdata, exp_wdata);
               check("rnd_req_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
               first_addr = mem_addr;
               cnt = $urandom_range(0, 2);
               phase = 1;
            end
            if (phase == 1 && cnt == 0) begin
               rsp_gnt = 1'b1;
               idx  = int'(mem_addr[31:2]);
               word = dut_mem.exists(idx) ? dut_mem[idx] : seed_word(idx);
               if (mem_wen) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_wmask[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
                  dut_mem[idx] = word;
               end
               pend  = word;
               phase = 2;
               cnt   = $urandom_range(1, 2);
            end
         end
      end
   end

   task automatic random_phase(input int cycles);
      bit          offered = 0, busy = 0, prev_valid = 0, prev_ready = 0, mem_op;
      beat_t       e;
      logic [31:0] held;
      logic [8:0]  typ;
      logic [31:0] res;
      held = 32'd0;
      for (int c = 0; c < cycles + 40; c++) begin
         @(negedge clk);
         if (out_valid && (!prev_valid || prev_ready)) begin
            if (exp_q.size() == 0) begin
               check("rnd_unexpected_beat", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rnd_type", {23'd0, out_type}, {23'd0, e.typ});
               check("rnd_result", out_result, e.result);
               check("rnd_memdata", out_memdata, e.memdata);
               check("rnd_snpc", out_snpc, e.snpc);
               check("rnd_err", {31'd0, err}, {31'd0, e.err});
            end
            held = out_result;
            busy = 0;
         end else begin
            check("rnd_err_quiet", {31'd0, err}, 32'd0);
            if (out_valid) check("rnd_hold", out_result, held);
         end
         prev_valid = out_valid;
         out_ready  = (c >= cycles) ? 1'b1 : ($urandom_range(0, 3) != 0);
         prev_ready = out_ready;
         if (!offered) in_valid = 1'b0;
         if (!offered && c < cycles && $urandom_range(0, 9) < 7) begin
            case ($urandom_range(0, 8))
               0: typ = T_ADDI;  1: typ = T_JALR; 2: typ = T_OTH2; 3: typ = T_LUI;
               4: typ = T_LW;    5: typ = T_LBU;  6: typ = T_SW;   7: typ = T_SB;
               default: typ = T_OTH3;
            endcase
            if (typ inside {T_LW, T_LBU, T_SW, T_SB}) begin
               res = 32'h80000000 + 32'($urandom_range(0, 63));
               if ((typ == T_LW || typ == T_SW) && $urandom_range(0, 3) != 0) res[1:0] = 2'b00;
            end else begin
               res = $urandom;
            end
            in_type = typ; in_result = res; in_sdata = $urandom; in_snpc = $urandom;
            in_valid = 1'b1; offered = 1;
         end
         #1;
         check("rnd_in_ready", {31'd0, in_ready}, {31'd0, (!busy && (!out_valid || out_ready))});
         if (in_valid && in_ready) begin
            model_accept(in_type, in_result, in_sdata, in_snpc, e, mem_op);
            exp_q.push_back(e);
            if (mem_op) busy = 1;
            offered = 0;
         end
      end
      in_valid = 1'b0;
      check("rnd_queue_drained", exp_q.size(), 32'd0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct packed {
      logic [8:0]  typ;
      logic [31:0] res, sd, snpc, rdata, e_addr, e_wdata;
      logic [3:0]  e_wmask;
      logic        e_memop;
      logic [31:0] e_memdata;
      logic        e_err;
   } vec_t;

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_type = v.typ; in_result = v.res; in_sdata = v.sd; in_snpc = v.snpc;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_mem_req", k), {31'd0, mem_req}, {31'd0, v.e_memop});
      if (v.e_memop) begin
         check($sformatf("v%0d_addr", k), mem_addr, v.e_addr);
         check($sformatf("v%0d_wen", k), {31'd0, mem_wen}, {31'd0, (v.typ == T_SW || v.typ == T_SB)});
         check($sformatf("v%0d_wdata", k), mem_wdata, v.e_wdata);
         check($sformatf("v%0d_wmask", k), {28'd0, mem_wmask}, {28'd0, v.e_wmask});
         man_gnt = 1'b1;
         @(negedge clk);
         man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = v.rdata;
         @(negedge clk);
         man_rvalid = 1'b0;
      end
      wait_out(n);
      check($sformatf("v%0d_latency", k), 32'(n), 32'd0);
      check($sformatf("v%0d_result", k), out_result, v.res);
      check($sformatf("v%0d_snpc", k), out_snpc, v.snpc);
      check($sformatf("v%0d_memdata", k), out_memdata, v.e_memdata);
      check($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, v.e_err});
   endtask

   vec_t vt [11];

   initial begin : main
      int n;
      rst_n = 1'b0; in_valid = 1'b0; in_type = 9'd0; in_result = 32'd0; in_sdata = 32'd0;
      in_snpc = 32'd0; out_ready = 1'b0; auto_mem = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;
      man_rdata = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_wmask = 4'd0; exp_wen = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;

      //        typ     res           sd            snpc          rdata         e_addr        e_wdata       mask  mop   memdata       err
      vt[0]  = {T_ADDI, 32'h00000005, 32'h0,        32'h80000004, 32'h0,        32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0};
      vt[1]  = {T_LBU,  32'h80000102, 32'h0,        32'h80000008, 32'hAABBCCDD, 32'h80000100, 32'h0,        4'h0, 1'b1, 32'h000000BB, 1'b0};
      vt[2]  = {T_LW,   32'h00000006, 32'h0,        32'h8000000C, 32'h0,        32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b1};
      vt[3]  = {T_LW,   32'h80000010, 32'h0,        32'h80000010, 32'h12345678, 32'h80000010, 32'h0,        4'h0, 1'b1, 32'h12345678, 1'b0};
      vt[4]  = {T_SW,   32'h80000020, 32'hDEADBEEF, 32'h80000014, 32'h0,        32'h80000020, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b0};
      vt[5]  = {T_SB,   32'h00000013, 32'h000001FF, 32'h80000018, 32'h0,        32'h00000010, 32'hFFFFFFFF, 4'h8, 1'b1, 32'h0,        1'b0};
      vt[6]  = {T_LBU,  32'h80000003, 32'h0,        32'h8000001C, 32'h11223344, 32'h80000000, 32'h0,        4'h0, 1'b1, 32'h00000011, 1'b0};
      vt[7]  = {T_LUI,  32'h12345000, 32'h0,        32'h80000020, 32'h0,        32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0};
      vt[8]  = {T_SW,   32'h00000022, 32'h55555555, 32'h80000024, 32'h0,        32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b1};
      vt[9]  = {T_JALR, 32'h80001000, 32'h0,        32'h80000028, 32'h0,        32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0};
      vt[10] = {T_SB,   32'h80000041, 32'h000000A5, 32'h8000002C, 32'h0,        32'h80000040, 32'hA5A5A5A5, 4'h2, 1'b1, 32'h0,        1'b0};
      for (int i = 0; i < 11; i++) run_vec(vt[i], i);

      // sb with two stall cycles before grant: request must stay stable
      @(negedge clk);
      in_valid = 1'b1; in_type = T_SB; in_result = 32'h13; in_sdata = 32'h1FF; in_snpc = 32'h4;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("stall_req", {31'd0, mem_req}, 32'd1);
         check("stall_addr", mem_addr, 32'h10);
         check("stall_wdata", mem_wdata, 32'hFFFFFFFF);
         check("stall_wmask", {28'd0, mem_wmask}, 32'h8);
         if (k < 2) @(negedge clk);
      end
      man_gnt = 1'b1;
      @(negedge clk);
      man_gnt = 1'b0;
      check("stall_req_drop", {31'd0, mem_req}, 32'd0);
      man_rvalid = 1'b1; man_rdata = 32'hFFFF0000;
      @(negedge clk);
      man_rvalid = 1'b0;
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_memdata", out_memdata, 32'd0);

      // WBU back-pressure holding an addi while a lw is offered
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_type = T_ADDI; in_result = 32'h77; in_snpc = 32'h44;
      @(negedge clk);
      in_type = T_LW; in_result = 32'h80000030; in_snpc = 32'h48;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_result", out_result, 32'h77);
         check("bp_type", {23'd0, out_type}, {23'd0, T_ADDI});
         check("bp_no_req", {31'd0, mem_req}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_drained", {31'd0, out_valid}, 32'd0);
      check("bp_lw_req", mem_addr, 32'h80000030);
      man_gnt = 1'b1;
      @(negedge clk);
      man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hCAFEF00D;
      @(negedge clk);
      man_rvalid = 1'b0;
      check("bp_lw_memdata", out_memdata, 32'hCAFEF00D);
      check("bp_lw_result", out_result, 32'h80000030);

      // lw granted but never answered: abort after TB_TIMEOUT cycles
      @(negedge clk);
      in_valid = 1'b1; in_type = T_LW; in_result = 32'h80000060; in_snpc = 32'h50;
      @(negedge clk);
      in_valid = 1'b0;
      check("tmo_req", {31'd0, mem_req}, 32'd1);
      man_gnt = 1'b1;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); man_gnt = 1'b0; n++; end
      check("tmo_cycles", 32'(n), 32'(TB_TIMEOUT));
      check("tmo_err", {31'd0, err}, 32'd1);
      check("tmo_memdata", out_memdata, 32'd0);
      check("tmo_idle", {31'd0, in_ready}, 32'd1);
      man_rvalid = 1'b1; man_rdata = 32'h12121212;
      @(negedge clk);
      man_rvalid = 1'b0;
      check("tmo_late_rvalid", {31'd0, out_valid}, 32'd0);
      check("tmo_err_pulse", {31'd0, err}, 32'd0);

      // reset asserted while waiting for a response
      in_valid = 1'b1; in_type = T_LW; in_result = 32'h80000050; in_snpc = 32'h60;
      @(negedge clk);
      in_valid = 1'b0;
      man_gnt = 1'b1;
      @(negedge clk);
      man_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstw_req", {31'd0, mem_req}, 32'd0);
      check("rstw_valid", {31'd0, out_valid}, 32'd0);
      check("rstw_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1; man_rvalid = 1'b1; man_rdata = 32'h99999999;
      @(negedge clk);
      man_rvalid = 1'b0;
      check("rstw_rvalid_ignored", {31'd0, out_valid}, 32'd0);
      check("rstw_err", {31'd0, err}, 32'd0);

      dut_mem.delete();
      ref_mem.delete();
      auto_mem = 1'b1;
      random_phase(400);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
